// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the Wishbone memory slave
package wb_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    localparam int BE_WIDTH      = WB_DATA_WIDTH / 8;
    localparam int WB_IDX_WIDTH  = WB_ADDR_WIDTH - 2;

    // One accepted beat; oor is resolved at accept time so service never re-decodes.
    typedef struct packed {
        logic                     we;
        logic                     oor;
        logic [WB_IDX_WIDTH-1:0]  idx;
        logic [WB_DATA_WIDTH-1:0] dat;
        logic [BE_WIDTH-1:0]      sel;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SLV_IDLE,
        WB_SLV_WAIT,
        WB_SLV_RESP
    } wb_slv_state_t;

endpackage

// File: rtl/wb_slv_req_q.sv
// rtl/wb_slv_req_q.sv - request queue with flush, full/empty/count
module wb_slv_req_q
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output wb_req_t          pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_req_t          entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = entries[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - pipelined Wishbone B4 slave backed by on-chip RAM
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int  ADDR_WIDTH  = WB_ADDR_WIDTH,
    parameter int  DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int  MEM_DEPTH   = 1024,
    parameter int  Q_DEPTH     = 4,
    parameter int  WAIT_STATES = 0,
    localparam int BE_W        = DATA_WIDTH / 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [BE_W-1:0]       wb_sel_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_rty_o
);

    localparam int                IDX_W     = $clog2(MEM_DEPTH);
    localparam int                CNT_W     = $clog2(Q_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BE_W);

    wb_req_t          req_in;
    wb_req_t          head;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic             accept;
    logic             resp_fire;
    logic             head_oor;
    logic [IDX_W-1:0] head_idx;

    wb_slv_state_t    state;
    wb_slv_state_t    state_d;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_cnt_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = (q_count == CNT_W'(Q_DEPTH));
    assign accept     = wb_cyc_i & wb_stb_i & ~q_full;

    always_comb begin
        req_in     = '0;
        req_in.we  = wb_we_i;
        req_in.oor = ({1'b0, wb_adr_i} >= MEM_BYTES);
        req_in.idx = WB_IDX_WIDTH'(wb_adr_i >> 2);
        req_in.dat = WB_DATA_WIDTH'(wb_dat_i);
        req_in.sel = BE_WIDTH'(wb_sel_i);
    end

    wb_slv_req_q #(
        .DEPTH(Q_DEPTH)
    ) u_req_q (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .flush     (~wb_cyc_i),
        .push      (accept),
        .push_data (req_in),
        .pop       (resp_fire),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Upper index bits can only be set on beats already flagged oor; folded in defensively.
    assign head_oor = head.oor | (|(head.idx >> IDX_W));
    assign head_idx = head.idx[IDX_W-1:0];

    // RESP is the cycle the ack/err is visible; it may immediately start the next beat.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        resp_fire  = 1'b0;
        case (state)
            WB_SLV_IDLE, WB_SLV_RESP: begin
                if (!q_empty) begin
                    if (WAIT_STATES == 0) begin
                        resp_fire = 1'b1;
                        state_d   = WB_SLV_RESP;
                    end else begin
                        wait_cnt_d = 4'(WAIT_STATES);
                        state_d    = WB_SLV_WAIT;
                    end
                end else begin
                    state_d = WB_SLV_IDLE;
                end
            end
            WB_SLV_WAIT: begin
                wait_cnt_d = wait_cnt - 1'b1;
                // The edge that takes the counter to zero is the response edge.
                if (wait_cnt == 4'd1) begin
                    resp_fire = 1'b1;
                    state_d   = WB_SLV_RESP;
                end
            end
            default: state_d = WB_SLV_IDLE;
        endcase
        if (!wb_cyc_i) begin
            state_d    = WB_SLV_IDLE;
            wait_cnt_d = '0;
            resp_fire  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= WB_SLV_IDLE;
            wait_cnt <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            wb_ack_o <= resp_fire & ~head_oor;
            wb_err_o <= resp_fire & head_oor;
            if (resp_fire) begin
                wb_dat_o <= (head.we || head_oor) ? '0 : mem[head_idx];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (resp_fire && head.we && !head_oor) begin
            for (int b = 0; b < BE_W; b++) begin
                if (head.sel[b]) begin
                    mem[head_idx][8*b +: 8] <= head.dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - directed self-checking bench for wb_mem_slave
module tb_wb_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [31:0] wdat  [2];
    logic [3:0]  sel   [2];
    logic        stall [2];
    logic        ack   [2];
    logic        err   [2];
    logic        rty   [2];
    logic [31:0] rdat  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_mem_slave #(.MEM_DEPTH(1024), .Q_DEPTH(4), .WAIT_STATES(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
        .wb_stall_o(stall[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
        .wb_dat_o(rdat[0]), .wb_rty_o(rty[0])
    );

    wb_mem_slave #(.MEM_DEPTH(1024), .Q_DEPTH(4), .WAIT_STATES(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
        .wb_stall_o(stall[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
        .wb_dat_o(rdat[1]), .wb_rty_o(rty[1])
    );

    task automatic single(input int d, input bit w, input logic [31:0] a, input logic [31:0] dv,
                          input logic [3:0] s, output logic [31:0] rd, output bit ga, output bit ge);
        ga = 1'b0;
        ge = 1'b0;
        rd = '0;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dv; sel[d] = s;
        @(negedge clk);
        stb[d] = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (ack[d] || err[d]) begin
                ga = ack[d];
                ge = err[d];
                rd = rdat[d];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = '0; wdat[d] = '0; sel[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
            checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
            checks++; if (rdat[d] !== 32'h0) begin errors++; $display("FAIL reset_dat[%0d]: got %h expected 0", d, rdat[d]); end
            checks++; if (stall[d] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", d, stall[d]); end
            checks++; if (rty[d] !== 1'b0) begin errors++; $display("FAIL reset_rty[%0d]: got %b expected 0", d, rty[d]); end
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; wdat[0] = 32'hDEADBEEF; sel[0] = 4'hF;
        @(negedge clk);
        stb[0] = 1'b0;
        checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b expected 0", ack[0]); end
        checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b expected 0", stall[0]); end
        @(negedge clk);
        checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b expected 1", ack[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err[0]); end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10;
        @(negedge clk);
        stb[0] = 1'b0;
        checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL wr_ack_width: got %b expected 0", ack[0]); end
        @(negedge clk);
        checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b expected 1", ack[0]); end
        checks++; if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rdat[0]); end
        @(negedge clk);
        checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL rd_ack_width: got %b expected 0", ack[0]); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        bit ga, ge;
        single(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, ga, ge);
        single(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, ga, ge);
        checks++; if (ga !== 1'b1) begin errors++; $display("FAIL be_wr_ack: got %b expected 1", ga); end
        single(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, ga, ge);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_burst();
        logic [31:0] rd;
        bit ga, ge;
        bit exp_ack;
        for (int i = 0; i < 4; i++) begin
            single(0, 1'b1, 32'h40 + 32'(4 * i), 32'hB0B00000 + 32'(i), 4'hF, rd, ga, ge);
        end
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            exp_ack = (t >= 2 && t <= 5);
            checks++; if (ack[0] !== exp_ack) begin errors++; $display("FAIL burst_ack t=%0d: got %b expected %b", t, ack[0], exp_ack); end
            if (exp_ack) begin
                checks++;
                if (rdat[0] !== 32'hB0B00000 + 32'(t - 2)) begin
                    errors++; $display("FAIL burst_data t=%0d: got %h expected %h", t, rdat[0], 32'hB0B00000 + 32'(t - 2));
                end
            end
            checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL burst_stall t=%0d: got %b expected 0", t, stall[0]); end
            if (t < 4) begin
                cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40 + 32'(4 * t);
            end else begin
                stb[0] = 1'b0;
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        bit ga, ge;
        single(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, ga, ge);
        single(0, 1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, rd, ga, ge);
        checks++; if (ga !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL top_word_ack: got ack=%b err=%b expected ack=1 err=0", ga, ge); end
        single(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, ga, ge);
        checks++; if (ge !== 1'b1 || ga !== 1'b0) begin errors++; $display("FAIL oor_wr: got ack=%b err=%b expected ack=0 err=1", ga, ge); end
        @(negedge clk);
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL oor_err_width: got %b expected 0", err[0]); end
        single(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, ga, ge);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_no_alias: got %h expected cafef00d", rd); end
        single(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, ga, ge);
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL top_word_rd: got %h expected 0badc0de", rd); end
        single(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, ga, ge);
        checks++; if (ge !== 1'b1 || ga !== 1'b0) begin errors++; $display("FAIL oor_rd: got ack=%b err=%b expected ack=0 err=1", ga, ge); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bit ga, ge;
        int n_sent, n_ack, stall_first;
        for (int i = 0; i < 8; i++) begin
            single(1, 1'b1, 32'h80 + 32'(4 * i), 32'h50000000 + 32'(i), 4'hF, rd, ga, ge);
        end
        n_sent = 0;
        n_ack = 0;
        stall_first = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ack[1]) begin
                checks++; if (t != 4 + 3 * n_ack) begin errors++; $display("FAIL b2b_ack_time beat %0d: got t=%0d expected t=%0d", n_ack, t, 4 + 3 * n_ack); end
                checks++; if (rdat[1] !== 32'h50000000 + 32'(n_ack)) begin errors++; $display("FAIL b2b_data beat %0d: got %h expected %h", n_ack, rdat[1], 32'h50000000 + 32'(n_ack)); end
                n_ack++;
            end
            if (err[1]) begin
                checks++; errors++; $display("FAIL b2b_err t=%0d: got err=1 expected 0", t);
            end
            if (t == 4) begin
                checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL b2b_push_pop_stall: got %b expected 0", stall[1]); end
            end
            if (stall[1] && stall_first < 0) stall_first = t;
            if (n_sent < 8) begin
                cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h80 + 32'(4 * n_sent);
                if (!stall[1]) n_sent++;
            end else begin
                stb[1] = 1'b0;
            end
        end
        checks++; if (n_ack != 8) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 8", n_ack); end
        checks++; if (stall_first != 5) begin errors++; $display("FAIL b2b_stall_first: got t=%0d expected t=5", stall_first); end
        checks++; if (n_sent != 8) begin errors++; $display("FAIL b2b_sent: got %0d expected 8", n_sent); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd;
        bit ga, ge;
        single(1, 1'b1, 32'h100, 32'h01010101, 4'hF, rd, ga, ge);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h100; wdat[1] = 32'h77777777; sel[1] = 4'hF;
        end
        @(negedge clk);
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t == 0) begin
                checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL drop_stall: got %b expected 0", stall[1]); end
            end
            checks++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
                errors++; $display("FAIL drop_resp t=%0d: got ack=%b err=%b expected 0 0", t, ack[1], err[1]);
            end
        end
        single(1, 1'b0, 32'h100, 32'h0, 4'hF, rd, ga, ge);
        checks++; if (ga !== 1'b1) begin errors++; $display("FAIL drop_reread_ack: got %b expected 1", ga); end
        checks++; if (rd !== 32'h01010101) begin errors++; $display("FAIL drop_discard: got %h expected 01010101", rd); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h80 + 32'(4 * i);
        end
        @(negedge clk);
        stb[1] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ack[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_first_ack: got none expected ack within 20 cycles"); end
        #1 rst_n[1] = 1'b0;
        #1;
        checks++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin errors++; $display("FAIL rstmid_async_resp: got ack=%b err=%b expected 0 0", ack[1], err[1]); end
        checks++; if (rdat[1] !== 32'h0) begin errors++; $display("FAIL rstmid_async_dat: got %h expected 0", rdat[1]); end
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL rstmid_async_stall: got %b expected 0", stall[1]); end
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
                errors++; $display("FAIL rstmid_after t=%0d: got ack=%b err=%b expected 0 0", t, ack[1], err[1]);
            end
        end
        cyc[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_burst();
        test_out_of_range();
        test_back_to_back();
        test_cyc_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
